// File: rtl/net_access_controller.sv
// Network access controller: stalls the pipeline around SWNET/LWNET, drives the outbound
// flit handshake and buffers inbound words in a small receive FIFO.
module net_access_controller #(
  parameter int unsigned RX_DEPTH = 4,
  parameter int unsigned TIMEOUT  = 1023
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        NET_WRITE,
  input  logic        NET_READ,
  input  logic [31:0] NET_ADDR,
  input  logic [31:0] NET_WDATA,
  output logic [31:0] NET_RDATA,
  output logic        NET_BUSY,
  output logic        NET_ERR,
  output logic        TX_VALID,
  input  logic        TX_READY,
  output logic [7:0]  TX_DEST,
  output logic [31:0] TX_DATA,
  input  logic        RX_VALID,
  input  logic [31:0] RX_DATA,
  output logic        RX_READY,
  output logic [2:0]  RX_COUNT
);

  localparam int unsigned PtrW = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt   = CntW'(RX_DEPTH);
  localparam logic [15:0]     TimeoutCnt = 16'(TIMEOUT);

  typedef enum logic [1:0] {
    StIdle,
    StTxWait,
    StRxWait,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [15:0]     wait_q, wait_d;
  logic [7:0]      tx_dest_q, tx_dest_d;
  logic [31:0]     tx_data_q, tx_data_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;

  logic [31:0]     mem_q [RX_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic [31:0]     count_ext;
  logic            push, pop, fifo_empty;
  logic            unused_addr;

  // Only the low byte of the address selects the destination node.
  assign unused_addr = ^NET_ADDR[31:8];

  assign fifo_empty = (count_q == '0);
  assign RX_READY   = (count_q < DepthCnt);
  assign push       = RX_VALID & RX_READY;

  assign count_ext = 32'(count_q);
  assign RX_COUNT  = (count_ext > 32'd7) ? 3'd7 : count_ext[2:0];

  assign NET_BUSY  = (NET_WRITE | NET_READ) & (state_q != StDone);
  assign TX_VALID  = (state_q == StTxWait);
  assign TX_DEST   = tx_dest_q;
  assign TX_DATA   = tx_data_q;
  assign NET_RDATA = rdata_q;
  assign NET_ERR   = err_q;

  always_comb begin
    state_d   = state_q;
    wait_d    = '0;
    tx_dest_d = tx_dest_q;
    tx_data_d = tx_data_q;
    rdata_d   = rdata_q;
    err_d     = 1'b0;
    pop       = 1'b0;

    unique case (state_q)
      StIdle: begin
        // A simultaneous read request is ignored in favour of the write.
        if (NET_WRITE) begin
          tx_dest_d = NET_ADDR[7:0];
          tx_data_d = NET_WDATA;
          state_d   = StTxWait;
        end else if (NET_READ) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            rdata_d = mem_q[rd_ptr_q];
            state_d = StDone;
          end else begin
            state_d = StRxWait;
          end
        end
      end

      StTxWait: begin
        wait_d = wait_q + 16'd1;
        if (TX_READY) begin
          state_d = StDone;
        end else if (wait_q == TimeoutCnt) begin
          state_d = StDone;
          err_d   = 1'b1;
        end
      end

      StRxWait: begin
        wait_d = wait_q + 16'd1;
        // Completion takes priority over a timeout landing in the same cycle.
        if (!fifo_empty) begin
          pop     = 1'b1;
          rdata_d = mem_q[rd_ptr_q];
          state_d = StDone;
        end else if (wait_q == TimeoutCnt) begin
          rdata_d = 32'hFFFF_FFFF;
          state_d = StDone;
          err_d   = 1'b1;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q   <= StIdle;
      wait_q    <= '0;
      tx_dest_q <= '0;
      tx_data_q <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      tx_dest_q <= tx_dest_d;
      tx_data_q <= tx_data_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      count_q <= count_q + CntW'(push) - CntW'(pop);
    end
  end

  // Storage needs no reset: the pointers and count define which entries are live.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= RX_DATA;
    end
  end

endmodule

// File: tb/tb_net_access_controller.sv
// Self-checking bench for net_access_controller: directed scenarios plus randomized ops
// checked against a queue-based reference model.
module tb_net_access_controller;

  localparam int unsigned Depth = 4;
  localparam int unsigned Tmo   = 8;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        NET_WRITE = 1'b0;
  logic        NET_READ = 1'b0;
  logic [31:0] NET_ADDR = '0;
  logic [31:0] NET_WDATA = '0;
  logic [31:0] NET_RDATA;
  logic        NET_BUSY;
  logic        NET_ERR;
  logic        TX_VALID;
  logic        TX_READY = 1'b0;
  logic [7:0]  TX_DEST;
  logic [31:0] TX_DATA;
  logic        RX_VALID = 1'b0;
  logic [31:0] RX_DATA = '0;
  logic        RX_READY;
  logic [2:0]  RX_COUNT;

  int checks = 0;
  int errors = 0;

  net_access_controller #(
    .RX_DEPTH(Depth),
    .TIMEOUT (Tmo)
  ) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .NET_WRITE(NET_WRITE),
    .NET_READ (NET_READ),
    .NET_ADDR (NET_ADDR),
    .NET_WDATA(NET_WDATA),
    .NET_RDATA(NET_RDATA),
    .NET_BUSY (NET_BUSY),
    .NET_ERR  (NET_ERR),
    .TX_VALID (TX_VALID),
    .TX_READY (TX_READY),
    .TX_DEST  (TX_DEST),
    .TX_DATA  (TX_DATA),
    .RX_VALID (RX_VALID),
    .RX_DATA  (RX_DATA),
    .RX_READY (RX_READY),
    .RX_COUNT (RX_COUNT)
  );

  always #5 CLK = ~CLK;

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic to_drive();
    @(posedge CLK);
    #1;
  endtask

  task automatic to_neg();
    @(negedge CLK);
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b1;
    to_neg();
    checks++; if (TX_VALID !== 1'b0) begin errors++; $display("FAIL rst_tx_valid: got %b want 0", TX_VALID); end
    checks++; if (TX_DEST !== 8'h00) begin errors++; $display("FAIL rst_tx_dest: got %h want 00", TX_DEST); end
    checks++; if (TX_DATA !== 32'h0) begin errors++; $display("FAIL rst_tx_data: got %h want 0", TX_DATA); end
    checks++; if (NET_RDATA !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h want 0", NET_RDATA); end
    checks++; if (NET_ERR !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", NET_ERR); end
    checks++; if (RX_READY !== 1'b1) begin errors++; $display("FAIL rst_rx_ready: got %b want 1", RX_READY); end
    checks++; if (RX_COUNT !== 3'd0) begin errors++; $display("FAIL rst_rx_count: got %0d want 0", RX_COUNT); end
    checks++; if (NET_BUSY !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", NET_BUSY); end
  endtask

  task automatic test_write_ready();
    to_drive();
    NET_WRITE = 1'b1; NET_ADDR = 32'h0000_0005; NET_WDATA = 32'hDEAD_BEEF; TX_READY = 1'b1;
    to_neg();
    checks++; if (NET_BUSY !== 1'b1) begin errors++; $display("FAIL wr_busy_c0: got %b want 1", NET_BUSY); end
    checks++; if (TX_VALID !== 1'b0) begin errors++; $display("FAIL wr_valid_c0: got %b want 0", TX_VALID); end
    to_drive();
    to_neg();
    checks++; if (NET_BUSY !== 1'b1) begin errors++; $display("FAIL wr_busy_c1: got %b want 1", NET_BUSY); end
    checks++; if (TX_VALID !== 1'b1) begin errors++; $display("FAIL wr_valid_c1: got %b want 1", TX_VALID); end
    checks++; if (TX_DEST !== 8'h05) begin errors++; $display("FAIL wr_dest: got %h want 05", TX_DEST); end
    checks++; if (TX_DATA !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_data: got %h want deadbeef", TX_DATA); end
    to_drive();
    to_neg();
    checks++; if (NET_BUSY !== 1'b0) begin errors++; $display("FAIL wr_busy_done: got %b want 0", NET_BUSY); end
    checks++; if (TX_VALID !== 1'b0) begin errors++; $display("FAIL wr_valid_done: got %b want 0", TX_VALID); end
    checks++; if (NET_ERR !== 1'b0) begin errors++; $display("FAIL wr_err_done: got %b want 0", NET_ERR); end
    to_drive();
    NET_WRITE = 1'b0; TX_READY = 1'b0;
  endtask

  task automatic test_write_stall();
    to_drive();
    NET_WRITE = 1'b1; NET_ADDR = 32'h1234_5677; NET_WDATA = 32'hA5A5_0F0F; TX_READY = 1'b0;
    to_neg();
    for (int i = 0; i < 3; i++) begin
      to_drive();
      to_neg();
      checks++; if (TX_VALID !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %b want 1", i, TX_VALID); end
      checks++; if (TX_DEST !== 8'h77) begin errors++; $display("FAIL stall_dest[%0d]: got %h want 77", i, TX_DEST); end
      checks++; if (TX_DATA !== 32'hA5A5_0F0F) begin errors++; $display("FAIL stall_data[%0d]: got %h want a5a50f0f", i, TX_DATA); end
      checks++; if (NET_BUSY !== 1'b1) begin errors++; $display("FAIL stall_busy[%0d]: got %b want 1", i, NET_BUSY); end
    end
    to_drive();
    TX_READY = 1'b1;
    to_neg();
    checks++; if (TX_VALID !== 1'b1) begin errors++; $display("FAIL stall_valid_hs: got %b want 1", TX_VALID); end
    to_drive();
    to_neg();
    checks++; if (NET_BUSY !== 1'b0) begin errors++; $display("FAIL stall_busy_done: got %b want 0", NET_BUSY); end
    checks++; if (TX_VALID !== 1'b0) begin errors++; $display("FAIL stall_valid_done: got %b want 0", TX_VALID); end
    to_drive();
    NET_WRITE = 1'b0; TX_READY = 1'b0;
  endtask

  task automatic test_write_timeout();
    int nb, ntv;
    bit early_err;
    nb = 0; ntv = 0; early_err = 1'b0;
    to_drive();
    NET_WRITE = 1'b1; NET_ADDR = 32'h0000_00AB; NET_WDATA = 32'h1357_9BDF; TX_READY = 1'b0;
    for (int c = 0; c < 30; c++) begin
      to_neg();
      if (!NET_BUSY) break;
      nb++;
      if (TX_VALID) ntv++;
      if (NET_ERR) early_err = 1'b1;
      to_drive();
    end
    checks++; if (nb != Tmo + 2) begin errors++; $display("FAIL wto_busy_cycles: got %0d want %0d", nb, Tmo + 2); end
    checks++; if (ntv != Tmo + 1) begin errors++; $display("FAIL wto_valid_cycles: got %0d want %0d", ntv, Tmo + 1); end
    checks++; if (early_err !== 1'b0) begin errors++; $display("FAIL wto_early_err: got %b want 0", early_err); end
    checks++; if (NET_ERR !== 1'b1) begin errors++; $display("FAIL wto_err: got %b want 1", NET_ERR); end
    checks++; if (TX_VALID !== 1'b0) begin errors++; $display("FAIL wto_valid_done: got %b want 0", TX_VALID); end
    to_drive();
    NET_WRITE = 1'b0;
    to_neg();
    checks++; if (NET_ERR !== 1'b0) begin errors++; $display("FAIL wto_err_pulse: got %b want 0", NET_ERR); end
  endtask

  task automatic test_fifo_full();
    logic [31:0] w [5];
    w = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55};
    for (int i = 0; i < 5; i++) begin
      to_drive();
      RX_VALID = 1'b1; RX_DATA = w[i];
      to_neg();
      checks++; if (RX_COUNT !== 3'(i < 4 ? i : 4)) begin errors++; $display("FAIL full_count[%0d]: got %0d want %0d", i, RX_COUNT, (i < 4 ? i : 4)); end
      checks++; if (RX_READY !== (i < 4)) begin errors++; $display("FAIL full_ready[%0d]: got %b want %b", i, RX_READY, (i < 4)); end
    end
    to_drive();
    NET_READ = 1'b1;
    to_neg();
    checks++; if (RX_COUNT !== 3'd4) begin errors++; $display("FAIL full_held_off: got %0d want 4", RX_COUNT); end
    to_drive();
    to_neg();
    checks++; if (NET_RDATA !== 32'h11) begin errors++; $display("FAIL full_rdata: got %h want 11", NET_RDATA); end
    checks++; if (RX_COUNT !== 3'd3) begin errors++; $display("FAIL full_count_pop: got %0d want 3", RX_COUNT); end
    checks++; if (RX_READY !== 1'b1) begin errors++; $display("FAIL full_ready_pop: got %b want 1", RX_READY); end
    checks++; if (NET_BUSY !== 1'b0) begin errors++; $display("FAIL full_busy_done: got %b want 0", NET_BUSY); end
    // The held-off 0x55 is accepted at the end of this cycle.
    to_drive();
    RX_VALID = 1'b0; NET_READ = 1'b0;
  endtask

  task automatic test_read_drain();
    logic [31:0] w [4];
    w = '{32'h22, 32'h33, 32'h44, 32'h55};
    for (int i = 0; i < 4; i++) begin
      to_drive();
      NET_READ = 1'b1;
      to_neg();
      checks++; if (NET_BUSY !== 1'b1) begin errors++; $display("FAIL drain_busy[%0d]: got %b want 1", i, NET_BUSY); end
      to_drive();
      to_neg();
      checks++; if (NET_RDATA !== w[i]) begin errors++; $display("FAIL drain_rdata[%0d]: got %h want %h", i, NET_RDATA, w[i]); end
      checks++; if (RX_COUNT !== 3'(3 - i)) begin errors++; $display("FAIL drain_count[%0d]: got %0d want %0d", i, RX_COUNT, 3 - i); end
      to_drive();
      NET_READ = 1'b0;
    end
  endtask

  task automatic test_read_wait();
    to_drive();
    NET_READ = 1'b1;
    to_neg();
    for (int i = 0; i < 4; i++) begin
      to_drive();
      to_neg();
      checks++; if (NET_BUSY !== 1'b1) begin errors++; $display("FAIL rwait_busy[%0d]: got %b want 1", i, NET_BUSY); end
    end
    to_drive();
    RX_VALID = 1'b1; RX_DATA = 32'hCAFE_0001;
    to_neg();
    to_drive();
    RX_VALID = 1'b0;
    to_neg();
    checks++; if (NET_BUSY !== 1'b1) begin errors++; $display("FAIL rwait_busy_pop: got %b want 1", NET_BUSY); end
    checks++; if (RX_COUNT !== 3'd1) begin errors++; $display("FAIL rwait_count_pop: got %0d want 1", RX_COUNT); end
    to_drive();
    to_neg();
    checks++; if (NET_BUSY !== 1'b0) begin errors++; $display("FAIL rwait_busy_done: got %b want 0", NET_BUSY); end
    checks++; if (NET_RDATA !== 32'hCAFE_0001) begin errors++; $display("FAIL rwait_rdata: got %h want cafe0001", NET_RDATA); end
    checks++; if (RX_COUNT !== 3'd0) begin errors++; $display("FAIL rwait_count: got %0d want 0", RX_COUNT); end
    to_drive();
    NET_READ = 1'b0;
  endtask

  task automatic test_read_timeout();
    int nb;
    bit early_err;
    logic [31:0] word;
    nb = 0; early_err = 1'b0; word = $urandom;
    to_drive();
    NET_READ = 1'b1;
    for (int c = 0; c < 30; c++) begin
      to_neg();
      if (!NET_BUSY) break;
      nb++;
      if (NET_ERR) early_err = 1'b1;
      to_drive();
    end
    checks++; if (nb != Tmo + 2) begin errors++; $display("FAIL rto_busy_cycles: got %0d want %0d", nb, Tmo + 2); end
    checks++; if (early_err !== 1'b0) begin errors++; $display("FAIL rto_early_err: got %b want 0", early_err); end
    checks++; if (NET_ERR !== 1'b1) begin errors++; $display("FAIL rto_err: got %b want 1", NET_ERR); end
    checks++; if (NET_RDATA !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rto_rdata: got %h want ffffffff", NET_RDATA); end
    to_drive();
    NET_READ = 1'b0;
    to_neg();
    checks++; if (NET_ERR !== 1'b0) begin errors++; $display("FAIL rto_err_pulse: got %b want 0", NET_ERR); end
    checks++; if (NET_RDATA !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rto_rdata_hold: got %h want ffffffff", NET_RDATA); end
    // Word arrives in the last wait cycle; its pop coincides with the timeout count.
    to_drive();
    NET_READ = 1'b1;
    to_neg();
    for (int i = 0; i < Tmo; i++) begin
      to_drive();
      RX_VALID = (i == Tmo - 1); RX_DATA = word;
      to_neg();
      checks++; if (NET_BUSY !== 1'b1) begin errors++; $display("FAIL rlast_busy[%0d]: got %b want 1", i, NET_BUSY); end
    end
    to_drive();
    RX_VALID = 1'b0;
    to_neg();
    checks++; if (NET_BUSY !== 1'b1) begin errors++; $display("FAIL rlast_busy_pop: got %b want 1", NET_BUSY); end
    to_drive();
    to_neg();
    checks++; if (NET_BUSY !== 1'b0) begin errors++; $display("FAIL rlast_busy_done: got %b want 0", NET_BUSY); end
    checks++; if (NET_ERR !== 1'b0) begin errors++; $display("FAIL rlast_err: got %b want 0", NET_ERR); end
    checks++; if (NET_RDATA !== word) begin errors++; $display("FAIL rlast_rdata: got %h want %h", NET_RDATA, word); end
    to_drive();
    NET_READ = 1'b0;
  endtask

  task automatic test_both();
    logic [31:0] w, prev;
    w = $urandom;
    prev = NET_RDATA;
    to_drive();
    RX_VALID = 1'b1; RX_DATA = w;
    to_drive();
    RX_VALID = 1'b0;
    NET_WRITE = 1'b1; NET_READ = 1'b1; NET_ADDR = 32'hFFFF_FF3C; NET_WDATA = 32'h0F0F_1234;
    TX_READY = 1'b1;
    to_neg();
    checks++; if (NET_BUSY !== 1'b1) begin errors++; $display("FAIL both_busy: got %b want 1", NET_BUSY); end
    to_drive();
    to_neg();
    checks++; if (TX_VALID !== 1'b1) begin errors++; $display("FAIL both_valid: got %b want 1", TX_VALID); end
    checks++; if (TX_DEST !== 8'h3C) begin errors++; $display("FAIL both_dest: got %h want 3c", TX_DEST); end
    checks++; if (RX_COUNT !== 3'd1) begin errors++; $display("FAIL both_count: got %0d want 1", RX_COUNT); end
    checks++; if (NET_RDATA !== prev) begin errors++; $display("FAIL both_rdata: got %h want %h", NET_RDATA, prev); end
    to_drive();
    to_neg();
    checks++; if (NET_BUSY !== 1'b0) begin errors++; $display("FAIL both_busy_done: got %b want 0", NET_BUSY); end
    to_drive();
    NET_WRITE = 1'b0; NET_READ = 1'b0; TX_READY = 1'b0;
    to_drive();
    NET_READ = 1'b1;
    to_drive();
    to_neg();
    checks++; if (NET_RDATA !== w) begin errors++; $display("FAIL both_read_after: got %h want %h", NET_RDATA, w); end
    to_drive();
    NET_READ = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    to_drive();
    RX_VALID = 1'b1; RX_DATA = 32'hAAAA_0001;
    to_drive();
    RX_DATA = 32'hAAAA_0002;
    to_drive();
    RX_VALID = 1'b0;
    NET_WRITE = 1'b1; NET_ADDR = 32'h0000_0042; NET_WDATA = 32'h7777_8888; TX_READY = 1'b0;
    to_neg();
    checks++; if (RX_COUNT !== 3'd2) begin errors++; $display("FAIL rmid_count_pre: got %0d want 2", RX_COUNT); end
    to_drive();
    to_neg();
    checks++; if (TX_VALID !== 1'b1) begin errors++; $display("FAIL rmid_valid_pre: got %b want 1", TX_VALID); end
    to_drive();
    RESET = 1'b0;
    to_drive();
    RESET = 1'b1; NET_WRITE = 1'b0;
    to_neg();
    checks++; if (TX_VALID !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b want 0", TX_VALID); end
    checks++; if (RX_COUNT !== 3'd0) begin errors++; $display("FAIL rmid_count: got %0d want 0", RX_COUNT); end
    checks++; if (NET_ERR !== 1'b0) begin errors++; $display("FAIL rmid_err: got %b want 0", NET_ERR); end
    checks++; if (TX_DEST !== 8'h00) begin errors++; $display("FAIL rmid_dest: got %h want 00", TX_DEST); end
    checks++; if (NET_RDATA !== 32'h0) begin errors++; $display("FAIL rmid_rdata: got %h want 0", NET_RDATA); end
    checks++; if (NET_BUSY !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b want 0", NET_BUSY); end
    checks++; if (RX_READY !== 1'b1) begin errors++; $display("FAIL rmid_ready: got %b want 1", RX_READY); end
  endtask

  // Reference model: FIFO as a queue, each op as issue -> wait (bounded) -> done.
  task automatic test_random();
    logic [31:0] q [$];
    logic [31:0] rdata_m, data_m;
    logic [7:0]  dest_m;
    int          phase, waited, sz, rx_rate, tx_rate;
    bit          is_wr, err_m, do_push;
    rdata_m = 32'h0;
    for (int op = 0; op < 60; op++) begin
      is_wr   = 1'($urandom_range(0, 1));
      rx_rate = $urandom_range(0, 3);
      tx_rate = $urandom_range(0, 3);
      phase   = 0;
      waited  = 0;
      err_m   = 1'b0;
      to_drive();
      NET_WRITE = is_wr;
      NET_READ  = is_wr ? 1'($urandom_range(0, 1)) : 1'b1;
      NET_ADDR  = $urandom;
      NET_WDATA = $urandom;
      dest_m    = NET_ADDR[7:0];
      data_m    = NET_WDATA;
      for (int cyc = 0; cyc < 40 && phase != 3; cyc++) begin
        if (cyc > 0) to_drive();
        RX_VALID = (int'($urandom_range(0, 3)) < rx_rate);
        RX_DATA  = $urandom;
        TX_READY = (int'($urandom_range(0, 3)) < tx_rate);
        to_neg();
        sz = q.size();
        checks++; if (NET_BUSY !== (phase != 2)) begin errors++; $display("FAIL rnd_busy op%0d cyc%0d: got %b want %b", op, cyc, NET_BUSY, (phase != 2)); end
        checks++; if (TX_VALID !== (is_wr && phase == 1)) begin errors++; $display("FAIL rnd_valid op%0d cyc%0d: got %b want %b", op, cyc, TX_VALID, (is_wr && phase == 1)); end
        checks++; if (NET_ERR !== (phase == 2 && err_m)) begin errors++; $display("FAIL rnd_err op%0d cyc%0d: got %b want %b", op, cyc, NET_ERR, (phase == 2 && err_m)); end
        checks++; if (NET_RDATA !== rdata_m) begin errors++; $display("FAIL rnd_rdata op%0d cyc%0d: got %h want %h", op, cyc, NET_RDATA, rdata_m); end
        checks++; if (RX_COUNT !== 3'(sz)) begin errors++; $display("FAIL rnd_count op%0d cyc%0d: got %0d want %0d", op, cyc, RX_COUNT, sz); end
        checks++; if (RX_READY !== (sz < Depth)) begin errors++; $display("FAIL rnd_ready op%0d cyc%0d: got %b want %b", op, cyc, RX_READY, (sz < Depth)); end
        if (is_wr && phase == 1) begin
          checks++; if (TX_DEST !== dest_m || TX_DATA !== data_m) begin errors++; $display("FAIL rnd_flit op%0d cyc%0d: got %h/%h want %h/%h", op, cyc, TX_DEST, TX_DATA, dest_m, data_m); end
        end
        do_push = RX_VALID && (sz < Depth);
        case (phase)
          0: begin
            if (is_wr || sz == 0) begin
              phase = 1; waited = 0;
            end else begin
              rdata_m = q.pop_front(); phase = 2;
            end
          end
          1: begin
            if (is_wr && TX_READY) begin
              phase = 2;
            end else if (!is_wr && sz > 0) begin
              rdata_m = q.pop_front(); phase = 2;
            end else if (waited == Tmo) begin
              phase = 2; err_m = 1'b1;
              if (!is_wr) rdata_m = 32'hFFFF_FFFF;
            end else begin
              waited++;
            end
          end
          default: phase = 3;
        endcase
        if (do_push) q.push_back(RX_DATA);
      end
    end
    to_drive();
    NET_WRITE = 1'b0; NET_READ = 1'b0; RX_VALID = 1'b0; TX_READY = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write_ready();
    test_write_stall();
    test_write_timeout();
    test_fifo_full();
    test_read_drain();
    test_read_wait();
    test_read_timeout();
    test_both();
    test_reset_mid_op();
    test_random();
    repeat (2) to_drive();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached with %0d checks", checks);
    $fatal(1);
  end

endmodule
